// File: rtl/fps_seq.sv
// fps_seq: multi-cycle floating-point subtractor, number_out = number_A - number_B.
// Alignment and normalisation move one bit per cycle. Denormals are flushed to zero.
// Rounding is round-to-nearest-even.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in the idle state
//   number_A, number_B   minuend and subtrahend, {sign, exponent, mantissa}
//   out_valid/out_ready  result handshake; the result is held while out_ready is low
//   number_out           difference
//   flags                {invalid, overflow, underflow, inexact, zero}
//                        (present only when FPS_FLAGS_EN is defined)
//
// Optional feature macro: FPS_FLAGS_EN adds the flags port and its registers.
// EXP_SIZE and MANTIS_SIZE defaults come from the macros of the same names (8 / 23).

`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fps_seq #(
  parameter int unsigned EXP_SIZE    = `EXP_SIZE,
  parameter int unsigned MANTIS_SIZE = `MANTIS_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] number_A,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] number_B,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_SIZE+MANTIS_SIZE:0] number_out
`ifdef FPS_FLAGS_EN
  ,
  output logic [4:0]                    flags
`endif
);

  localparam int unsigned W         = 1 + EXP_SIZE + MANTIS_SIZE;
  localparam int unsigned MW        = MANTIS_SIZE + 4;  // hidden + mantissa + guard/round/sticky
  localparam int unsigned EW        = EXP_SIZE + 2;     // two's complement working exponent
  localparam int unsigned ALIGN_LIM = MANTIS_SIZE + 3;
  localparam int unsigned CNT_W     = $clog2(ALIGN_LIM + 1);

  localparam logic [EXP_SIZE-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANTIS_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic                 sub_q, sub_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [MW:0]          mant_g_q, mant_g_d;  // top bit catches the adder carry
  logic [MW-1:0]        mant_s_q, mant_s_d;
  logic [EXP_SIZE-1:0]  diff_q, diff_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         out_q, out_d;

  // Operand unpack; B's sign is inverted so the rest of the block only adds.
  logic                   a_sign, b_sign;
  logic [EXP_SIZE-1:0]    a_exp, b_exp;
  logic [MANTIS_SIZE-1:0] a_man, b_man;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
  logic [W-1:0]           a_pk, b_pk;

  assign a_sign = number_A[W-1];
  assign b_sign = ~number_B[W-1];
  assign a_exp  = number_A[W-2:MANTIS_SIZE];
  assign b_exp  = number_B[W-2:MANTIS_SIZE];
  assign a_man  = number_A[MANTIS_SIZE-1:0];
  assign b_man  = number_B[MANTIS_SIZE-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
  assign a_ge   = number_A[W-2:0] >= number_B[W-2:0];
  assign a_pk   = {a_sign, a_zero ? {(W-1){1'b0}} : number_A[W-2:0]};
  assign b_pk   = {b_sign, b_zero ? {(W-1){1'b0}} : number_B[W-2:0]};

  logic         spec_hit;
  logic [W-1:0] spec_res;
`ifdef FPS_FLAGS_EN
  logic [4:0]   spec_flags, flags_q, flags_d;
`endif

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
`ifdef FPS_FLAGS_EN
    spec_flags = '0;
`endif
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      spec_res = QNAN;
`ifdef FPS_FLAGS_EN
      spec_flags = 5'b10000;
`endif
    end else if (a_inf) begin
      spec_res = a_pk;
    end else if (b_inf) begin
      spec_res = b_pk;
    end else if (number_A == number_B) begin
      spec_res = '0;
`ifdef FPS_FLAGS_EN
      spec_flags = 5'b00001;
`endif
    end else if (a_zero) begin
      spec_res = b_pk;
`ifdef FPS_FLAGS_EN
      spec_flags = {4'b0000, b_zero};
`endif
    end else if (b_zero) begin
      spec_res = a_pk;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Round-to-nearest-even on the normalised mantissa; a carry renormalises in place.
  logic                   rnd_up;
  logic [MANTIS_SIZE+1:0] rnd_sum;
  logic [EW-1:0]          rnd_exp;
  logic [MANTIS_SIZE-1:0] rnd_frac;

  assign rnd_up   = mant_g_q[2] & (mant_g_q[1] | mant_g_q[0] | mant_g_q[3]);
  assign rnd_sum  = {1'b0, mant_g_q[MW-1:3]} + {{(MANTIS_SIZE+1){1'b0}}, rnd_up};
  assign rnd_exp  = exp_q + {{(EW-1){1'b0}}, rnd_sum[MANTIS_SIZE+1]};
  assign rnd_frac = rnd_sum[MANTIS_SIZE+1] ? rnd_sum[MANTIS_SIZE:1] : rnd_sum[MANTIS_SIZE-1:0];

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    mant_g_d = mant_g_q;
    mant_s_d = mant_s_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
`ifdef FPS_FLAGS_EN
    flags_d  = flags_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (spec_hit) begin
            out_d   = spec_res;
`ifdef FPS_FLAGS_EN
            flags_d = spec_flags;
`endif
            state_d = StDone;
          end else begin
            sub_d = a_sign ^ b_sign;
            cnt_d = '0;
            if (a_ge) begin
              sign_d   = a_sign;
              exp_d    = {2'b00, a_exp};
              mant_g_d = {2'b01, a_man, 3'b000};
              mant_s_d = {1'b1, b_man, 3'b000};
              diff_d   = a_exp - b_exp;
            end else begin
              sign_d   = b_sign;
              exp_d    = {2'b00, b_exp};
              mant_g_d = {2'b01, b_man, 3'b000};
              mant_s_d = {1'b1, a_man, 3'b000};
              diff_d   = b_exp - a_exp;
            end
            state_d = StAlign;
          end
        end
      end
      StAlign: begin
        if (diff_q == '0) begin
          state_d = StAdd;
        end else begin
          mant_s_d = {1'b0, mant_s_q[MW-1:2], mant_s_q[1] | mant_s_q[0]};
          diff_d   = diff_q - EXP_SIZE'(1);
          cnt_d    = cnt_q + CNT_W'(1);
          // Last allowed shift: everything left of the small operand is sticky.
          if (cnt_q == CNT_W'(ALIGN_LIM - 1)) begin
            mant_s_d = {{(MW-1){1'b0}}, |mant_s_q};
            state_d  = StAdd;
          end
        end
      end
      StAdd: begin
        mant_g_d = sub_q ? mant_g_q - {1'b0, mant_s_q} : mant_g_q + {1'b0, mant_s_q};
        state_d  = StNorm;
      end
      StNorm: begin
        if (mant_g_q[MW]) begin
          mant_g_d = {1'b0, mant_g_q[MW:2], mant_g_q[1] | mant_g_q[0]};
          exp_d    = exp_q + EW'(1);
        end else if (mant_g_q[MW-1] || (mant_g_q == '0)) begin
          state_d = StRound;
        end else begin
          mant_g_d = {mant_g_q[MW-1:0], 1'b0};
          exp_d    = exp_q - EW'(1);
        end
      end
      StRound: begin
        if (!mant_g_q[MW-1]) begin
          out_d   = '0;
`ifdef FPS_FLAGS_EN
          flags_d = 5'b00001;
`endif
        end else if (!rnd_exp[EW-1] && (rnd_exp >= {2'b00, EXP_ONES})) begin
          out_d   = {sign_q, EXP_ONES, {MANTIS_SIZE{1'b0}}};
`ifdef FPS_FLAGS_EN
          flags_d = 5'b01000;
`endif
        end else if (rnd_exp[EW-1] || (rnd_exp == '0)) begin
          out_d   = {sign_q, {(W-1){1'b0}}};
`ifdef FPS_FLAGS_EN
          flags_d = 5'b00111;
`endif
        end else begin
          out_d   = {sign_q, rnd_exp[EXP_SIZE-1:0], rnd_frac};
`ifdef FPS_FLAGS_EN
          flags_d = {3'b000, |mant_g_q[2:0], 1'b0};
`endif
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= '0;
      mant_g_q <= '0;
      mant_s_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
`ifdef FPS_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      exp_q    <= exp_d;
      mant_g_q <= mant_g_d;
      mant_s_q <= mant_s_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
`ifdef FPS_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign number_out = out_q;
`ifdef FPS_FLAGS_EN
  assign flags      = flags_q;
`endif

endmodule

// File: tb/tb_fps_seq.sv
// Directed bench for fps_seq (8/23 format). Latency is counted in clock edges after
// the accepting edge; special cases reach the done state on the accepting edge itself.
module tb_fps_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number_a;
  logic [31:0] number_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] number_out;
`ifdef FPS_FLAGS_EN
  logic [4:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  fps_seq #(
    .EXP_SIZE    (8),
    .MANTIS_SIZE (23)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .number_A   (number_a),
    .number_B   (number_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .number_out (number_out)
`ifdef FPS_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    logic [4:0]  flg;  // {invalid, overflow, underflow, inexact, zero}
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one operand pair, measure latency, check result, then complete the handshake.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    number_a = v.a;
    number_b = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("vec%0d result", idx), number_out, v.res);
`ifdef FPS_FLAGS_EN
    check($sformatf("vec%0d flags", idx), 32'(flags), 32'(v.flg));
`endif
    @(posedge clk);
    #1;
    check($sformatf("vec%0d idle after handshake", idx), 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int  lat;
    logic seen;

    //           a             b             result        lat flags
    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 5,  5'b00000}; // 3-1
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 0,  5'b00001}; // x-x
    vecs[2]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 0,  5'b10000}; // inf-inf
    vecs[3]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5,  5'b01000}; // overflow
    vecs[4]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 30, 5'b00010}; // 1-2^-30
    vecs[5]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 6,  5'b00000}; // 1-2
    vecs[6]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 5,  5'b00000}; // 1-(-1)
    vecs[7]  = '{32'h00000000, 32'h40A00000, 32'hC0A00000, 0,  5'b00000}; // 0-5
    vecs[8]  = '{32'h40E00000, 32'h00000000, 32'h40E00000, 0,  5'b00000}; // 7-0
    vecs[9]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 0,  5'b10000}; // NaN-1
    vecs[10] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 0,  5'b00000}; // inf-1
    vecs[11] = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 0,  5'b00000}; // 1-inf
    vecs[12] = '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 6,  5'b00000}; // 1.5-1.25
    vecs[13] = '{32'h3F800000, 32'hB3800000, 32'h3F800000, 28, 5'b00010}; // tie, even
    vecs[14] = '{32'h3F800001, 32'hB3800000, 32'h3F800002, 28, 5'b00010}; // tie, odd
    vecs[15] = '{32'h00800000, 32'h00C00000, 32'h80000000, 5,  5'b00111}; // underflow

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    number_a  = '0;
    number_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset number_out", number_out, 32'h0);
`ifdef FPS_FLAGS_EN
    check("reset flags", 32'(flags), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Backpressure: result held, no re-accept, busy in_valid ignored.
    out_ready = 1'b0;
    @(negedge clk);
    number_a = 32'h40400000;
    number_b = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'd5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      number_a = 32'h3F800000;
      number_b = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("bp hold result c%0d", c), number_out, 32'h40000000);
      check($sformatf("bp hold status c%0d", c), 32'({in_ready, out_valid}), 32'b01);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release idle", 32'({in_ready, out_valid}), 32'b10);
    check("bp release result", number_out, 32'h40000000);

    // Reset while aligning the long 1 - 2^-30 operation: the operation is discarded.
    @(negedge clk);
    number_a = 32'h3F800000;
    number_b = 32'h30800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-align reset out_valid", 32'(out_valid), 32'd0);
    check("mid-align reset number_out", number_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid-align release status", 32'({in_ready, out_valid}), 32'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("discarded op stays silent", 32'(seen), 32'd0);

    run_vec(vecs[12], 12);
    run_vec(vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
